bert_seq_ctrl: RTL

Test sequencer for the PRBS-13 bit-error-ratio tester. It loads and enables the PRBS-13 generator and the checker, acquires checker sync, then counts measured bits and bit errors over a programmed test length. It sits between the host/start logic and the generator/checker pair, and presents final counts to the readout path.

---
 rtl/bert_pkg.sv | 19 +
 rtl/bert_sat_counter.sv | 43 ++++
 rtl/bert_seq_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bert_pkg.sv
// Shared types and constants for the PRBS-13 bit-error-ratio tester.
package bert_pkg;

  localparam int unsigned PRBS13_W     = 13;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned SYNC_WIN_DEF = 64;

  localparam logic [PRBS13_W-1:0] PRBS13_SEED = 13'h1FFF;

  // Test sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SYNC    = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/bert_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky saturation flag.
module bert_sat_counter
  import bert_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  // Count up to all-ones, then hold; the flag rises as the count reaches all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc) begin
      if (r_count == CNT_MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
        if (r_count == CNT_MAX - CNT_W'(1)) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/bert_seq_ctrl.sv
// Test sequencer: seeds the PRBS-13 generator/checker, waits for checker sync,
// then measures bit and error counts over a programmed test length.
module bert_seq_ctrl
  import bert_pkg::*;
#(
  parameter int unsigned          CNT_W    = CNT_W_DEF,
  parameter int unsigned          SYNC_WIN = SYNC_WIN_DEF,
  parameter logic [PRBS13_W-1:0]  SEED     = PRBS13_SEED
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [CNT_W-1:0]    i_test_len,
  input  logic                i_rx_valid,
  input  logic                i_rx_err,
  output logic                o_gen_load,
  output logic                o_chk_load,
  output logic                o_gen_en,
  output logic [PRBS13_W-1:0] o_seed,
  output logic                o_busy,
  output logic                o_synced,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_bit_count,
  output logic [CNT_W-1:0]    o_err_count,
  output logic                o_err_ovf
);

  localparam int unsigned     WIN_W    = $clog2(SYNC_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYNC_WIN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_gen_load;
  logic             r_chk_load;
  logic             r_gen_en;
  logic             r_busy;
  logic             r_synced;
  logic             r_done;

  logic w_good;
  logic w_bad;
  logic w_start_acc;
  logic w_sync_hit;
  logic w_meas_bit;
  logic w_last_bit;
  logic w_err_inc;

  // Qualified events that steer the sequencer and counters
  assign w_good      = i_rx_valid & ~i_rx_err;
  assign w_bad       = i_rx_valid & i_rx_err;
  assign w_start_acc = i_start & ~i_abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_sync_hit  = (r_state == SYNC) & w_good & (r_win == WIN_LAST);
  assign w_meas_bit  = (r_state == MEASURE) & i_rx_valid & ~i_abort;
  assign w_last_bit  = w_meas_bit & (r_bit_count == r_len - CNT_W'(1));
  assign w_err_inc   = w_meas_bit & i_rx_err;

  // Sequencer: state register plus outputs decoded from the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_gen_load <= 1'b0;
      r_chk_load <= 1'b0;
      r_gen_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_synced   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_gen_load <= 1'b0;
      r_chk_load <= 1'b0;
      if (i_abort) begin
        r_state  <= IDLE;
        r_gen_en <= 1'b0;
        r_busy   <= 1'b0;
        r_synced <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (w_start_acc) begin
              r_state    <= LOAD;
              r_gen_load <= 1'b1;
              r_chk_load <= 1'b1;
              r_gen_en   <= 1'b0;
              r_busy     <= 1'b1;
              r_synced   <= 1'b0;
              r_done     <= 1'b0;
            end
          end
          LOAD: begin
            r_state  <= SYNC;
            r_gen_en <= 1'b1;
            r_busy   <= 1'b1;
          end
          SYNC: begin
            if (w_sync_hit) begin
              if (r_len == '0) begin
                r_state  <= DONE;
                r_gen_en <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_state  <= MEASURE;
                r_synced <= 1'b1;
              end
            end else if (w_bad) begin
              r_chk_load <= 1'b1;
            end
          end
          MEASURE: begin
            if (w_last_bit) begin
              r_state  <= DONE;
              r_gen_en <= 1'b0;
              r_busy   <= 1'b0;
              r_synced <= 1'b0;
              r_done   <= 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_gen_en <= 1'b0;
            r_busy   <= 1'b0;
            r_synced <= 1'b0;
            r_done   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Run of consecutive clean bits seen while acquiring sync
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win <= '0;
    end else if (i_abort || (r_state != SYNC) || w_sync_hit || w_bad) begin
      r_win <= '0;
    end else if (w_good) begin
      r_win <= r_win + WIN_W'(1);
    end
  end

  // Test length captured when a start is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
    end else if (w_start_acc) begin
      r_len <= i_test_len;
    end
  end

  // Measured bit counter; stops at the test length so it cannot wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_count <= '0;
    end else if (w_start_acc) begin
      r_bit_count <= '0;
    end else if (w_meas_bit) begin
      r_bit_count <= r_bit_count + CNT_W'(1);
    end
  end

  bert_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_acc),
    .i_inc   (w_err_inc),
    .o_count (o_err_count),
    .o_sat   (o_err_ovf)
  );

  assign o_gen_load  = r_gen_load;
  assign o_chk_load  = r_chk_load;
  assign o_gen_en    = r_gen_en;
  assign o_seed      = SEED;
  assign o_busy      = r_busy;
  assign o_synced    = r_synced;
  assign o_done      = r_done;
  assign o_bit_count = r_bit_count;

endmodule
